// File: rtl/uart_rx_os_if.sv
// Word-delivery channel of the oversampling UART receiver: received word, error flags and
// the valid/ready handshake towards the consumer.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output m_data, m_valid, frame_err, parity_err,
    input  m_ready
  );

  modport slave (
    input  m_data, m_valid, frame_err, parity_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start-edge resync, 3-sample majority per bit, framing/parity/
// overrun reporting, one-word output register on a valid/ready channel.
module uart_rx_os #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         os_tick,
  input  logic         rx_in,
  uart_rx_os_if.master m_if,
  output logic         overrun,
  output logic         rx_busy
);

  localparam int unsigned OsW = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] MidLo  = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [OsW-1:0] Mid    = OsW'(OVERSAMPLE / 2);
  localparam logic [OsW-1:0] MidHi  = OsW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [1:0]           sync_q, sync_d;
  logic [2:0]           state_q, state_d;
  logic [OsW-1:0]       os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic                 bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 line_idle_q, line_idle_d;
  logic [DATA_BITS-1:0] m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rxs, maj, bit_end, done;

  assign sync_d  = {sync_q[0], rx_in};
  assign rxs     = sync_q[1];
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
  assign bit_end = (os_cnt_q == OsLast);

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    perr_d      = perr_q;
    line_idle_d = line_idle_q;
    done        = 1'b0;

    if (state_q == StIdle) begin
      // After a break the line must be seen high before another start edge counts.
      if (rxs) line_idle_d = 1'b1;
      if (os_tick && !rxs && line_idle_q) begin
        state_d   = StStart;
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
      end
    end else if (os_tick) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == MidLo) samp_d[0] = rxs;
      if (os_cnt_q == Mid)   samp_d[1] = rxs;
      if (os_cnt_q == MidHi) bit_d     = maj;

      case (state_q)
        StStart: begin
          if (os_cnt_q == MidHi && maj) begin
            state_d     = StIdle;
            line_idle_d = 1'b0;
          end else if (bit_end) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          if (bit_end) begin
            shift_d   = {bit_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == DataLast) begin
              bit_cnt_d = '0;
              state_d   = PARITY_EN ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            perr_d  = (^shift_q) ^ bit_q ^ PARITY_ODD;
            state_d = StStop;
          end
        end
        StStop: begin
          // Last stop bit finishes at mid-bit so a back-to-back start edge is not missed.
          if (bit_cnt_q == StopLast) begin
            if (os_cnt_q == MidHi) begin
              ferr_d      = ferr_q | ~maj;
              done        = 1'b1;
              state_d     = StIdle;
              line_idle_d = 1'b0;
            end
          end else if (bit_end) begin
            ferr_d    = ferr_q | ~bit_q;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;
    if (done) begin
      if (!m_valid_q || m_if.m_ready) begin
        m_data_d     = shift_q;
        frame_err_d  = ferr_d;
        parity_err_d = perr_q;
        m_valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_if.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      os_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      samp_q       <= '0;
      bit_q        <= 1'b0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      line_idle_q  <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      line_idle_q  <= line_idle_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign m_if.m_data     = m_data_q;
  assign m_if.m_valid    = m_valid_q;
  assign m_if.frame_err  = frame_err_q;
  assign m_if.parity_err = parity_err_q;
  assign overrun         = overrun_q;
  assign rx_busy         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: three configurations (8N1, 8E1, 7N2) driven with serial
// frames built from data/parity/stop rules; a monitor pops expected words on each transfer.
module tb_uart_rx_os;
  localparam int Os = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic os_tick = 1'b0;
  logic rx [3];
  logic ready [3];
  logic mv [3], fe [3], pe [3], ov [3], busy [3];
  logic [8:0] md [3];
  bit   rand_ready [3];
  bit   force_ready [3];
  int   ov_seen [3];
  int   ov_exp [3];
  int   vectors = 0;
  int   miscompares = 0;
  logic [10:0] q0[$], q1[$], q2[$];  // {parity_err, frame_err, data}

  uart_rx_os_if #(.DATA_BITS(8)) if_a ();
  uart_rx_os_if #(.DATA_BITS(8)) if_b ();
  uart_rx_os_if #(.DATA_BITS(7)) if_c ();

  uart_rx_os dut_a (.clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(rx[0]), .m_if(if_a),
                    .overrun(ov[0]), .rx_busy(busy[0]));
  uart_rx_os #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(rx[1]), .m_if(if_b),
    .overrun(ov[1]), .rx_busy(busy[1]));
  uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_in(rx[2]), .m_if(if_c),
    .overrun(ov[2]), .rx_busy(busy[2]));

  assign if_a.m_ready = ready[0];
  assign if_b.m_ready = ready[1];
  assign if_c.m_ready = ready[2];
  assign mv[0] = if_a.m_valid;  assign md[0] = {1'b0, if_a.m_data};
  assign mv[1] = if_b.m_valid;  assign md[1] = {1'b0, if_b.m_data};
  assign mv[2] = if_c.m_valid;  assign md[2] = {2'b0, if_c.m_data};
  assign fe[0] = if_a.frame_err;  assign pe[0] = if_a.parity_err;
  assign fe[1] = if_b.frame_err;  assign pe[1] = if_b.parity_err;
  assign fe[2] = if_c.frame_err;  assign pe[2] = if_c.parity_err;

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      os_tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      ready[i] = rand_ready[i] ? ($urandom_range(0, 3) != 0) : force_ready[i];
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [10:0] qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int i, input logic [10:0] e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int dbits(input int idx);
    return (idx == 2) ? 7 : 8;
  endfunction

  function automatic int nstop(input int idx);
    return (idx == 2) ? 2 : 1;
  endfunction

  // Expected word from the frame contents alone.
  function automatic logic [10:0] model(input int idx, input logic [8:0] data, input logic pbit,
                                        input logic [1:0] stops);
    logic [8:0] d;
    logic       ferr, perr;
    d    = data & ((9'd1 << dbits(idx)) - 9'd1);
    ferr = (stops[0] == 1'b0) || (nstop(idx) == 2 && stops[1] == 1'b0);
    perr = (idx == 1) && ((($countones(d) + int'(pbit)) % 2) != 0);
    return {perr, ferr, d};
  endfunction

  function automatic int build(input int idx, input logic [8:0] data, input logic pbit,
                               input logic [1:0] stops, output logic [15:0] bits);
    int n;
    bits    = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < dbits(idx); i++) begin
      bits[n] = data[i];
      n++;
    end
    if (idx == 1) begin
      bits[n] = pbit;
      n++;
    end
    for (int s = 0; s < nstop(idx); s++) begin
      bits[n] = stops[s];
      n++;
    end
    return n;
  endfunction

  task automatic wait_tick();
    @(posedge clk iff os_tick);
    #2;
  endtask

  // Each bit spans Os tick intervals; noise flips one interval that the receiver samples.
  task automatic drive_bits(input int idx, input logic [15:0] bits, input int n,
                            input bit noisy);
    int np;
    for (int b = 0; b < n; b++) begin
      np = noisy ? Os / 2 + int'($urandom_range(0, 2)) : -1;
      for (int k = 0; k < Os; k++) begin
        wait_tick();
        rx[idx] = bits[b] ^ (k == np);
      end
    end
  endtask

  task automatic idle(input int idx, input int ticks);
    for (int k = 0; k < ticks; k++) begin
      wait_tick();
      rx[idx] = 1'b1;
    end
  endtask

  task automatic send_frame(input int idx, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input bit noisy, input bit push);
    logic [15:0] bits;
    int n;
    n = build(idx, data, pbit, stops, bits);
    if (push) qpush(idx, model(idx, data, pbit, stops));
    drive_bits(idx, bits, n, noisy);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((qsize(0) + qsize(1) + qsize(2)) != 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_pending", 0, qsize(0) + qsize(1) + qsize(2), 0);
  endtask

  task automatic chk_reset_outputs(input string name, input int i);
    chk({name, "_m_valid"}, i, mv[i], 0);
    chk({name, "_m_data"}, i, md[i], 0);
    chk({name, "_frame_err"}, i, fe[i], 0);
    chk({name, "_parity_err"}, i, pe[i], 0);
    chk({name, "_overrun"}, i, ov[i], 0);
    chk({name, "_rx_busy"}, i, busy[i], 0);
  endtask

  // Monitor: every transfer must match the oldest expected word of that receiver.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) ov_seen[i]++;
        if (mv[i] && ready[i]) begin
          if (qsize(i) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_word[%0d]: got data %0h, expected no word", i, md[i]);
          end else begin
            e = qpop(i);
            chk("m_data", i, md[i], e[8:0]);
            chk("frame_err", i, fe[i], e[9]);
            chk("parity_err", i, pe[i], e[10]);
          end
        end
      end
    end
  end

  initial begin
    logic [8:0] d;
    logic [1:0] st;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1;
      force_ready[i] = 1'b1;
      rand_ready[i] = 1'b0;
      ov_seen[i] = 0;
      ov_exp[i] = 0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk_reset_outputs("reset", i);
    #1 rst_n = 1'b1;
    idle(0, 2 * Os);

    // 8N1 basic word
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0, 1'b1);
    idle(0, 2 * Os);
    drain();

    // Short low glitch is rejected as a false start
    for (int k = 0; k < 5; k++) begin
      wait_tick();
      rx[0] = 1'b0;
    end
    wait_tick();
    rx[0] = 1'b1;
    idle(0, 2);
    chk("glitch_busy_high", 0, busy[0], 1);
    idle(0, 2 * Os);
    chk("glitch_busy_low", 0, busy[0], 0);
    chk("glitch_no_valid", 0, mv[0], 0);

    // Even parity: 0x03 with wrong and correct parity bit
    send_frame(1, 9'h003, 1'b1, 2'b11, 1'b0, 1'b1);
    idle(1, Os);
    send_frame(1, 9'h003, 1'b0, 2'b11, 1'b0, 1'b1);
    idle(1, 2 * Os);
    drain();

    // Bad stop bit, then a 12-bit-time break, then recovery
    send_frame(0, 9'h05A, 1'b0, 2'b10, 1'b0, 1'b1);
    idle(0, 2 * Os);
    qpush(0, {1'b0, 1'b1, 9'h000});
    for (int k = 0; k < 12 * Os; k++) begin
      wait_tick();
      rx[0] = 1'b0;
    end
    idle(0, 2 * Os);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0, 1'b1);
    idle(0, 2 * Os);
    drain();

    // Overrun: consumer stalled, two back-to-back frames
    force_ready[0] = 1'b0;
    repeat (2) @(posedge clk);
    send_frame(0, 9'h011, 1'b0, 2'b11, 1'b0, 1'b1);
    send_frame(0, 9'h022, 1'b0, 2'b11, 1'b0, 1'b0);
    ov_exp[0]++;
    idle(0, 2 * Os);
    @(negedge clk);
    chk("stall_m_valid", 0, mv[0], 1);
    chk("stall_m_data", 0, md[0], 9'h011);
    chk("overrun_count", 0, ov_seen[0], ov_exp[0]);
    force_ready[0] = 1'b1;
    drain();
    repeat (2) @(negedge clk);
    chk("after_accept_valid", 0, mv[0], 0);

    // 7N2 with single-sample noise, including a bad first stop bit
    for (int i = 0; i < 3; i++) rand_ready[i] = 1'b1;
    send_frame(2, 9'h055, 1'b0, 2'b11, 1'b1, 1'b1);
    idle(2, Os);
    send_frame(2, 9'h02B, 1'b0, 2'b10, 1'b1, 1'b1);
    idle(2, 2 * Os);
    for (int n = 0; n < 10; n++) begin
      d = 9'($urandom_range(0, 127));
      send_frame(2, d, 1'b0, 2'b11, 1'b1, 1'b1);
      if ($urandom_range(0, 1) != 0) idle(2, Os);
    end
    idle(2, 2 * Os);

    // Random 8N1 (occasional bad stop) and 8E1 (random parity bit)
    for (int n = 0; n < 8; n++) begin
      d  = 9'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send_frame(0, d, 1'b0, st, 1'b0, 1'b1);
      if (st != 2'b11 || $urandom_range(0, 1) != 0) idle(0, Os);
    end
    idle(0, 2 * Os);
    for (int n = 0; n < 8; n++) begin
      d = 9'($urandom_range(0, 255));
      send_frame(1, d, 1'($urandom_range(0, 1)), 2'b11, 1'b0, 1'b1);
      if ($urandom_range(0, 1) != 0) idle(1, Os);
    end
    idle(1, 2 * Os);
    drain();
    for (int i = 0; i < 3; i++) chk("overrun_total", i, ov_seen[i], ov_exp[i]);

    // Reset in the middle of a frame discards it
    begin
      logic [15:0] bits;
      int n;
      n = build(2, 9'h02A, 1'b0, 2'b11, bits);
      drive_bits(2, bits, 4, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midframe_reset", 2);
    rx[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2, 12 * Os);
    chk("post_reset_busy", 2, busy[2], 0);
    chk("post_reset_valid", 2, mv[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
